wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 24 ++
 rtl/wb_stage_load_align.sv | 31 +++
 rtl/wb_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// Shared core definitions for the write-back stage: result-source encodings,
// load funct3 codes and FSM state encoding.
package wb_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_WAIT_LOAD = 2'b01,
        S_COMMIT    = 2'b10
    } state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: picks the byte/halfword lane from the raw
// memory word and sign- or zero-extends it according to funct3.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[8*offset +: 8];
        // Halfword lane ignores offset[0]; misaligned halves are not split.
        half_lane = rdata[16*offset[1] +: 16];
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LH:   data = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_lane};
            F3_LW:   data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: accepts instructions from MEM, waits for load data when
// needed, and drives a one-cycle register-file write plus a retire counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [1:0]      mem_wb_sel,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic [2:0]      mem_funct3,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_reg_write,
    output logic [31:0]     instret
);

    state_e          state;
    logic [4:0]      pend_rd;
    logic            pend_we;
    logic [2:0]      pend_funct3;
    logic [1:0]      pend_offset;
    logic            accept;
    logic [XLEN-1:0] direct_data;
    logic [XLEN-1:0] load_data;

    assign mem_ready = (state != S_WAIT_LOAD);
    assign accept    = mem_valid && mem_ready;

    always_comb begin
        case (mem_wb_sel)
            WB_ALU:  direct_data = mem_alu_result;
            WB_PC4:  direct_data = mem_pc_plus4;
            default: direct_data = '0;
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (dmem_rdata),
        .offset (pend_offset),
        .funct3 (pend_funct3),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rd           <= '0;
            wb_data      <= '0;
            wb_reg_write <= 1'b0;
            instret      <= '0;
            pend_rd      <= '0;
            pend_we      <= 1'b0;
            pend_funct3  <= '0;
            pend_offset  <= '0;
        end else begin
            wb_reg_write <= 1'b0;
            if (state == S_COMMIT) begin
                instret <= instret + 32'd1;
            end
            case (state)
                S_WAIT_LOAD: begin
                    if (dmem_rvalid) begin
                        rd           <= pend_rd;
                        wb_data      <= load_data;
                        wb_reg_write <= pend_we && (pend_rd != '0);
                        state        <= S_COMMIT;
                    end
                end
                default: begin
                    // IDLE and COMMIT behave alike: take a new instruction or idle.
                    if (accept) begin
                        if (mem_wb_sel == WB_LOAD) begin
                            pend_rd     <= mem_rd;
                            pend_we     <= mem_reg_write;
                            pend_funct3 <= mem_funct3;
                            pend_offset <= mem_alu_result[1:0];
                            state       <= S_WAIT_LOAD;
                        end else begin
                            rd           <= mem_rd;
                            wb_data      <= direct_data;
                            wb_reg_write <= mem_reg_write && (mem_rd != '0);
                            state        <= S_COMMIT;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
